// File: rtl/squash_unit_l2.sv
// Registered, age-ordered squash arbiter with commit-tracked head pointer.
// Optional shadow filter enabled by defining SQUASH_UNIT_L2_SHADOW_FILTER_EN.
module squash_unit_l2 #(
    parameter int unsigned p_num_arb       = 4,
    parameter int unsigned p_seq_num_bits  = 5,
    parameter int unsigned p_target_bits   = 32,
    parameter int unsigned p_shadow_cycles = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [p_num_arb-1:0]                  arb_val,
    input  logic [p_num_arb*p_seq_num_bits-1:0]   arb_seq_num,
    input  logic [p_num_arb*p_target_bits-1:0]    arb_target,
    output logic                                  gnt_val,
    output logic [p_seq_num_bits-1:0]             gnt_seq_num,
    output logic [p_target_bits-1:0]              gnt_target,
    input  logic                                  commit_val,
    input  logic [p_seq_num_bits-1:0]             commit_seq_num
);

    typedef logic [p_seq_num_bits-1:0] seq_t;
    typedef logic [p_target_bits-1:0]  tgt_t;

    localparam int unsigned lp_levels = (p_num_arb > 1) ? $clog2(p_num_arb) : 0;
    localparam int unsigned lp_leaves = 1 << lp_levels;
    localparam int unsigned lp_nodes  = 2 * lp_leaves - 1;

    seq_t head_q, head_d;

    // Heap-ordered compare tree: node n has children 2n+1 and 2n+2, leaves at the tail.
    logic node_val [lp_nodes];
    seq_t node_seq [lp_nodes];
    seq_t node_rel [lp_nodes];
    tgt_t node_tgt [lp_nodes];

    for (genvar i = 0; i < lp_leaves; i++) begin : g_leaf
        if (i < p_num_arb) begin : g_real
            assign node_val[lp_leaves-1+i] = arb_val[i];
            assign node_seq[lp_leaves-1+i] = arb_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
            assign node_tgt[lp_leaves-1+i] = arb_target[i*p_target_bits +: p_target_bits];
            assign node_rel[lp_leaves-1+i] =
                arb_seq_num[i*p_seq_num_bits +: p_seq_num_bits] - head_q;
        end else begin : g_pad
            assign node_val[lp_leaves-1+i] = 1'b0;
            assign node_seq[lp_leaves-1+i] = '0;
            assign node_tgt[lp_leaves-1+i] = '0;
            assign node_rel[lp_leaves-1+i] = '0;
        end
    end

    // Left subtree holds lower indices, so ties resolve to the lowest index.
    for (genvar n = 0; n < lp_leaves - 1; n++) begin : g_node
        logic take_left;
        assign take_left = node_val[2*n+1] &&
                           (!node_val[2*n+2] || (node_rel[2*n+1] <= node_rel[2*n+2]));
        assign node_val[n] = take_left ? node_val[2*n+1] : node_val[2*n+2];
        assign node_seq[n] = take_left ? node_seq[2*n+1] : node_seq[2*n+2];
        assign node_tgt[n] = take_left ? node_tgt[2*n+1] : node_tgt[2*n+2];
        assign node_rel[n] = take_left ? node_rel[2*n+1] : node_rel[2*n+2];
    end

    logic cand_val;
    seq_t cand_seq;
    tgt_t cand_tgt;
    logic accept;

    assign cand_val = node_val[0];
    assign cand_seq = node_seq[0];
    assign cand_tgt = node_tgt[0];

`ifdef SQUASH_UNIT_L2_SHADOW_FILTER_EN
    localparam int unsigned lp_cnt_bits = $clog2(p_shadow_cycles + 1);
    typedef logic [lp_cnt_bits-1:0] cnt_t;

    seq_t shadow_seq_q, shadow_seq_d;
    cnt_t shadow_cnt_q, shadow_cnt_d;
    seq_t shadow_rel;

    assign shadow_rel = shadow_seq_q - head_q;
    // Only a strictly older candidate may pass an active shadow.
    assign accept = cand_val && ((shadow_cnt_q == '0) || (node_rel[0] < shadow_rel));

    always_comb begin
        shadow_seq_d = shadow_seq_q;
        shadow_cnt_d = shadow_cnt_q;
        if (accept) begin
            shadow_seq_d = cand_seq;
            shadow_cnt_d = cnt_t'(p_shadow_cycles);
        end else if (commit_val && (commit_seq_num == shadow_seq_q)) begin
            shadow_cnt_d = '0;
        end else if (shadow_cnt_q != '0) begin
            shadow_cnt_d = shadow_cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_seq_q <= '0;
            shadow_cnt_q <= '0;
        end else begin
            shadow_seq_q <= shadow_seq_d;
            shadow_cnt_q <= shadow_cnt_d;
        end
    end
`else
    logic unused_shadow;
    assign unused_shadow = (p_shadow_cycles != 0) ^ (^node_rel[0]);
    assign accept = cand_val;
`endif

    always_comb begin
        head_d = head_q;
        if (commit_val) begin
            head_d = commit_seq_num + seq_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            gnt_val     <= 1'b0;
            gnt_seq_num <= '0;
            gnt_target  <= '0;
        end else begin
            head_q  <= head_d;
            gnt_val <= accept;
            if (accept) begin
                gnt_seq_num <= cand_seq;
                gnt_target  <= cand_tgt;
            end
        end
    end

endmodule

// File: tb/tb_squash_unit_l2.sv
// Randomised and directed bench for squash_unit_l2 against an integer reference model.
// Honours SQUASH_UNIT_L2_SHADOW_FILTER_EN the same way the design does.
module tb_squash_unit_l2;

    localparam int NA = 4;
    localparam int SB = 5;
    localparam int TB = 32;
    localparam int SHADOW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NA-1:0]    arb_val;
    logic [NA*SB-1:0] arb_seq_num;
    logic [NA*TB-1:0] arb_target;
    logic             gnt_val;
    logic [SB-1:0]    gnt_seq_num;
    logic [TB-1:0]    gnt_target;
    logic             c_val;
    logic [SB-1:0]    c_seq;

    logic          a_val [NA];
    logic [SB-1:0] a_seq [NA];
    logic [TB-1:0] a_tgt [NA];

    int total = 0;
    int bad = 0;

    // Reference model state
    int            m_head;
    int            m_cnt;
    logic [SB-1:0] m_sseq;
    logic          e_val;
    logic [SB-1:0] e_seq;
    logic [TB-1:0] e_tgt;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NA; i++) begin
            arb_val[i]             = a_val[i];
            arb_seq_num[i*SB +: SB] = a_seq[i];
            arb_target[i*TB +: TB]  = a_tgt[i];
        end
    end

    squash_unit_l2 #(
        .p_num_arb      (NA),
        .p_seq_num_bits (SB),
        .p_target_bits  (TB),
        .p_shadow_cycles(SHADOW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_val       (arb_val),
        .arb_seq_num   (arb_seq_num),
        .arb_target    (arb_target),
        .gnt_val       (gnt_val),
        .gnt_seq_num   (gnt_seq_num),
        .gnt_target    (gnt_target),
        .commit_val    (c_val),
        .commit_seq_num(c_seq)
    );

    function automatic int rel(input logic [SB-1:0] x);
        return (int'(x) - m_head + 32) % 32;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NA; i++) begin
            a_val[i] = 1'b0;
            a_seq[i] = '0;
            a_tgt[i] = '0;
        end
        c_val = 1'b0;
        c_seq = '0;
    endtask

    task automatic set_arb(input int i, input int s, input int t);
        a_val[i] = 1'b1;
        a_seq[i] = SB'(s);
        a_tgt[i] = TB'(t);
    endtask

    // Advance one clock: predict the registered result of the current inputs.
    task automatic step();
        int best;
        bit acc;
        best = -1;
        for (int i = 0; i < NA; i++) begin
            if (a_val[i] && (best < 0 || rel(a_seq[i]) < rel(a_seq[best]))) best = i;
        end
        acc = (best >= 0);
`ifdef SQUASH_UNIT_L2_SHADOW_FILTER_EN
        if (acc && m_cnt > 0 && rel(a_seq[best]) >= rel(m_sseq)) acc = 1'b0;
        if (acc) begin
            m_sseq = a_seq[best];
            m_cnt  = SHADOW;
        end else if (c_val && c_seq == m_sseq) begin
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
`endif
        if (acc) begin
            e_val = 1'b1;
            e_seq = a_seq[best];
            e_tgt = a_tgt[best];
        end else begin
            e_val = 1'b0;
        end
        if (c_val) m_head = (int'(c_seq) + 1) % 32;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_head = 0;
        m_cnt  = 0;
        m_sseq = '0;
        e_val  = 1'b0;
        e_seq  = '0;
        e_tgt  = '0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (gnt_val !== 1'b0 || gnt_seq_num !== 5'd0 || gnt_target !== 32'd0) begin
            bad++;
            $display("FAIL por_zero: got val=%0b seq=%0d tgt=%0h want 0/0/0",
                     gnt_val, gnt_seq_num, gnt_target);
        end
        do_reset();
        set_arb(0, 3, 'h33);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd3) begin
            bad++;
            $display("FAIL pre_reset_gnt: got val=%0b seq=%0d want 1/3", gnt_val, gnt_seq_num);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt_val !== 1'b0 || gnt_seq_num !== 5'd0 || gnt_target !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got val=%0b seq=%0d tgt=%0h want 0/0/0",
                     gnt_val, gnt_seq_num, gnt_target);
        end
        do_reset();
        // head=0 after reset: seq 0 is older than seq 31
        set_arb(1, 31, 'h1F);
        set_arb(2, 0, 'h20);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd0 || gnt_target !== 32'h20) begin
            bad++;
            $display("FAIL reset_head: got val=%0b seq=%0d tgt=%0h want 1/0/20",
                     gnt_val, gnt_seq_num, gnt_target);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        set_arb(1, 7, 'h100);
        set_arb(3, 3, 'h200);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd3 || gnt_target !== 32'h200) begin
            bad++;
            $display("FAIL arb_pick: got val=%0b seq=%0d tgt=%0h want 1/3/200",
                     gnt_val, gnt_seq_num, gnt_target);
        end
        step();
        total++;
        if (gnt_val !== 1'b0 || gnt_seq_num !== 5'd3 || gnt_target !== 32'h200) begin
            bad++;
            $display("FAIL arb_pulse_hold: got val=%0b seq=%0d tgt=%0h want 0/3/200",
                     gnt_val, gnt_seq_num, gnt_target);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        c_val = 1'b1;
        c_seq = 5'd29;
        step();
        set_arb(0, 1, 'hA0);
        set_arb(2, 31, 'hB0);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd31 || gnt_target !== 32'hB0) begin
            bad++;
            $display("FAIL wrap: got val=%0b seq=%0d tgt=%0h want 1/31/b0",
                     gnt_val, gnt_seq_num, gnt_target);
        end
    endtask

    task automatic test_tie();
        do_reset();
        set_arb(0, 4, 'hA);
        set_arb(2, 4, 'hB);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd4 || gnt_target !== 32'hA) begin
            bad++;
            $display("FAIL tie: got val=%0b seq=%0d tgt=%0h want 1/4/a",
                     gnt_val, gnt_seq_num, gnt_target);
        end
    endtask

`ifdef SQUASH_UNIT_L2_SHADOW_FILTER_EN
    task automatic test_shadow();
        do_reset();
        set_arb(0, 3, 3);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd3) begin
            bad++;
            $display("FAIL shadow_c0: got val=%0b seq=%0d want 1/3", gnt_val, gnt_seq_num);
        end
        set_arb(0, 5, 5);
        step();
        total++;
        if (gnt_val !== 1'b0) begin
            bad++;
            $display("FAIL shadow_c1_drop: got val=%0b want 0", gnt_val);
        end
        set_arb(0, 2, 2);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd2) begin
            bad++;
            $display("FAIL shadow_c2_older: got val=%0b seq=%0d want 1/2", gnt_val, gnt_seq_num);
        end
        for (int c = 3; c <= 5; c++) begin
            set_arb(0, 6, 6);
            step();
            total++;
            if (gnt_val !== 1'b0) begin
                bad++;
                $display("FAIL shadow_c%0d_drop: got val=%0b want 0", c, gnt_val);
            end
        end
        set_arb(0, 6, 6);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd6) begin
            bad++;
            $display("FAIL shadow_c6_open: got val=%0b seq=%0d want 1/6", gnt_val, gnt_seq_num);
        end
    endtask

    task automatic test_commit_clear();
        do_reset();
        set_arb(0, 8, 8);
        step();
        c_val = 1'b1;
        c_seq = 5'd8;
        step();
        set_arb(0, 9, 9);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd9) begin
            bad++;
            $display("FAIL commit_clear: got val=%0b seq=%0d want 1/9", gnt_val, gnt_seq_num);
        end
        // Reused seq number equal to the shadow must pass once the commit cleared it.
        do_reset();
        set_arb(0, 8, 'h80);
        step();
        c_val = 1'b1;
        c_seq = 5'd8;
        step();
        set_arb(0, 8, 'h81);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd8 || gnt_target !== 32'h81) begin
            bad++;
            $display("FAIL commit_clear_reuse: got val=%0b seq=%0d tgt=%0h want 1/8/81",
                     gnt_val, gnt_seq_num, gnt_target);
        end
    endtask
`else
    task automatic test_filter_off();
        do_reset();
        set_arb(0, 3, 3);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd3) begin
            bad++;
            $display("FAIL nofilter_first: got val=%0b seq=%0d want 1/3", gnt_val, gnt_seq_num);
        end
        set_arb(0, 5, 5);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd5) begin
            bad++;
            $display("FAIL nofilter_second: got val=%0b seq=%0d want 1/5", gnt_val, gnt_seq_num);
        end
    endtask
`endif

    task automatic test_reset_mid_shadow();
        do_reset();
        set_arb(0, 3, 3);
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt_val !== 1'b0 || gnt_seq_num !== 5'd0 || gnt_target !== 32'd0) begin
            bad++;
            $display("FAIL mid_shadow_reset: got val=%0b seq=%0d tgt=%0h want 0/0/0",
                     gnt_val, gnt_seq_num, gnt_target);
        end
        do_reset();
        set_arb(0, 9, 9);
        step();
        total++;
        if (gnt_val !== 1'b1 || gnt_seq_num !== 5'd9) begin
            bad++;
            $display("FAIL post_reset_gnt: got val=%0b seq=%0d want 1/9", gnt_val, gnt_seq_num);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NA; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 7) == 0) set_arb(i, int'($urandom_range(0, 31)),
                                                           int'($urandom));
                    else set_arb(i, (m_head + int'($urandom_range(0, 12))) % 32,
                                 int'($urandom));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                c_val = 1'b1;
                if ($urandom_range(0, 1) == 0) c_seq = m_sseq;
                else c_seq = SB'((m_head + int'($urandom_range(0, 3))) % 32);
            end
            step();
            total++;
            if (gnt_val !== e_val || gnt_seq_num !== e_seq || gnt_target !== e_tgt) begin
                bad++;
                $display("FAIL random[%0d]: got val=%0b seq=%0d tgt=%0h want %0b/%0d/%0h",
                         n, gnt_val, gnt_seq_num, gnt_target, e_val, e_seq, e_tgt);
            end
        end
    endtask

    initial begin
        clear_inputs();
        m_head = 0;
        m_cnt  = 0;
        m_sseq = '0;
        e_val  = 1'b0;
        e_seq  = '0;
        e_tgt  = '0;
        test_reset();
        test_arbitration();
        test_wrap();
        test_tie();
`ifdef SQUASH_UNIT_L2_SHADOW_FILTER_EN
        test_shadow();
        test_commit_clear();
`else
        test_filter_off();
`endif
        test_reset_mid_shadow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
